// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feeder and drain stages.
package systolic_pkg;

   localparam int unsigned SYS_ELEM_WIDTH = 32;

   typedef enum logic {
      FEED  = 1'b0,
      DRAIN = 1'b1
   } skew_state_e;

   // LSB position of a lane within a packed lane vector.
   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/skew_lane.sv
// depth_p-stage shift register of {data, valid, last}; every stage moves on adv_i.
// A bubble entering stage 0 keeps the previous data word instead of zeroing it.
module skew_lane
   import systolic_pkg::*;
#(
   parameter int unsigned width_p = SYS_ELEM_WIDTH,
   parameter int unsigned depth_p = 1
)
(
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               adv_i,
   input  logic [width_p-1:0] data_i,
   input  logic               valid_i,
   input  logic               last_i,
   output logic [width_p-1:0] data_o,
   output logic               valid_o,
   output logic               last_o
);

   logic [width_p-1:0] r_data [depth_p];
   logic [depth_p-1:0] r_valid;
   logic [depth_p-1:0] r_last;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int unsigned k = 0; k < depth_p; k++) begin
            r_data[k] <= '0;
         end
         r_valid <= '0;
         r_last  <= '0;
      end else if (adv_i) begin
         if (valid_i) begin
            r_data[0] <= data_i;
         end
         r_valid[0] <= valid_i;
         r_last[0]  <= last_i & valid_i;
         for (int unsigned k = 1; k < depth_p; k++) begin
            r_data[k]  <= r_data[k-1];
            r_valid[k] <= r_valid[k-1];
            r_last[k]  <= r_last[k-1];
         end
      end
   end

   assign data_o  = r_data[depth_p-1];
   assign valid_o = r_valid[depth_p-1];
   assign last_o  = r_last[depth_p-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder for one operand side of the systolic array: lane j lags lane 0 by j advances.
// Optional stall counter output enabled by defining SKEW_FEEDER_STALL_CNT_EN.
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int unsigned width_p = SYS_ELEM_WIDTH,
   parameter int unsigned lanes_p = 2
)
(
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [lanes_p*width_p-1:0] vec_i,
   input  logic                       vec_valid_i,
   input  logic                       vec_last_i,
   output logic                       vec_ready_o,
   output logic [lanes_p*width_p-1:0] data_o,
   output logic [lanes_p-1:0]         valid_o,
   output logic [lanes_p-1:0]         flush_o,
   input  logic [lanes_p-1:0]         ready_i
`ifdef SKEW_FEEDER_STALL_CNT_EN
   ,
   output logic [31:0]                stall_cnt_o
`endif
);

   localparam int unsigned CNT_W = (lanes_p > 1) ? $clog2(lanes_p) : 1;

   skew_state_e        r_state;
   skew_state_e        w_state_nxt;
   logic [CNT_W-1:0]   r_drain_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_adv;
   logic               w_accept;
   logic [lanes_p-1:0] w_last;

   assign w_adv       = &(ready_i | ~valid_o);
   assign vec_ready_o = w_adv & (r_state == FEED);
   assign w_accept    = vec_valid_i & vec_ready_o;
   assign flush_o     = w_last & valid_o;

   for (genvar j = 0; j < lanes_p; j++) begin : g_lane
      skew_lane #(
         .width_p (width_p),
         .depth_p (j + 1)
      ) u_lane (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .adv_i   (w_adv),
         .data_i  (vec_i[lane_lsb(j, width_p) +: width_p]),
         .valid_i (w_accept),
         .last_i  (vec_last_i & w_accept),
         .data_o  (data_o[lane_lsb(j, width_p) +: width_p]),
         .valid_o (valid_o[j]),
         .last_o  (w_last[j])
      );
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state     <= FEED;
         r_drain_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= w_cnt_nxt;
      end
   end

   // drain_cnt counts remaining bubble slots; leaving on the advance that
   // consumes the last one gives exactly lanes_p-1 bubbles on lane 0.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_drain_cnt;
      unique case (r_state)
         FEED: begin
            if (w_accept && vec_last_i && (lanes_p > 1)) begin
               w_state_nxt = DRAIN;
               w_cnt_nxt   = CNT_W'(lanes_p - 1);
            end
         end
         DRAIN: begin
            if (w_adv) begin
               if (r_drain_cnt <= CNT_W'(1)) begin
                  w_state_nxt = FEED;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_drain_cnt - 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = FEED;
            w_cnt_nxt   = '0;
         end
      endcase
   end

`ifdef SKEW_FEEDER_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_stall_cnt <= '0;
      end else if ((|(valid_o & ~ready_i)) && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: a 2-lane table of cycle vectors plus
// hand sequences for mid-matrix reset and a 1-lane instance.
module tb_systolic_skew_feeder;
   import systolic_pkg::*;

   logic        clk = 1'b0;
   logic        reset_i = 1'b0;
   always #5 clk = ~clk;

   // two-lane instance
   logic [63:0] vec;
   logic        vec_valid, vec_last, vec_ready;
   logic [63:0] data;
   logic [1:0]  valid, flush, ready;

   // one-lane instance
   logic [31:0] vec1;
   logic        vec1_valid, vec1_last, vec1_ready;
   logic [31:0] data1;
   logic        valid1, flush1, ready1;

`ifdef SKEW_FEEDER_STALL_CNT_EN
   logic [31:0] stall_cnt, stall_cnt1;
`endif

   systolic_skew_feeder #(.width_p(32), .lanes_p(2)) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .vec_i       (vec),
      .vec_valid_i (vec_valid),
      .vec_last_i  (vec_last),
      .vec_ready_o (vec_ready),
      .data_o      (data),
      .valid_o     (valid),
      .flush_o     (flush),
      .ready_i     (ready)
`ifdef SKEW_FEEDER_STALL_CNT_EN
      ,
      .stall_cnt_o (stall_cnt)
`endif
   );

   systolic_skew_feeder #(.width_p(32), .lanes_p(1)) dut1 (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .vec_i       (vec1),
      .vec_valid_i (vec1_valid),
      .vec_last_i  (vec1_last),
      .vec_ready_o (vec1_ready),
      .data_o      (data1),
      .valid_o     (valid1),
      .flush_o     (flush1),
      .ready_i     (ready1)
`ifdef SKEW_FEEDER_STALL_CNT_EN
      ,
      .stall_cnt_o (stall_cnt1)
`endif
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          rst;
      logic        v;
      logic        l;
      logic [31:0] in1;
      logic [31:0] in0;
      logic [1:0]  rdy;
      logic        e_vr;
      logic [1:0]  e_valid;
      logic [1:0]  e_flush;
      logic [31:0] e_d1;
      logic [31:0] e_d0;
      bit          sc_chk;
      logic [31:0] e_sc;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(bit rst, logic v, logic l, logic [31:0] in1, logic [31:0] in0,
                               logic [1:0] rdy, logic e_vr, logic [1:0] e_valid,
                               logic [1:0] e_flush, logic [31:0] e_d1, logic [31:0] e_d0,
                               bit sc_chk, logic [31:0] e_sc);
      vec_t r;
      r.rst = rst; r.v = v; r.l = l; r.in1 = in1; r.in0 = in0; r.rdy = rdy;
      r.e_vr = e_vr; r.e_valid = e_valid; r.e_flush = e_flush;
      r.e_d1 = e_d1; r.e_d0 = e_d0; r.sc_chk = sc_chk; r.e_sc = e_sc;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_i = 1'b1;
      step();
   endtask

   task automatic drive(input logic v, input logic l, input logic [31:0] in1,
                        input logic [31:0] in0, input logic [1:0] rdy);
      vec_valid = v;
      vec_last  = l;
      vec       = {in1, in0};
      ready     = rdy;
   endtask

   initial begin
      vec = '0; vec_valid = 1'b0; vec_last = 1'b0; ready = 2'b11;
      vec1 = '0; vec1_valid = 1'b0; vec1_last = 1'b0; ready1 = 1'b1;

      // rst v l in1 in0 rdy | vr valid flush d1 d0 | stall check
      // Scenario 1: all ready, two slices, second is last
      tbl[0]  = mk(1, 1, 0, 32'd6,  32'd13, 2'b11, 1, 2'b00, 2'b00, 32'd0,  32'd0,  1, 32'd0);
      tbl[1]  = mk(0, 1, 1, 32'd27, 32'd45, 2'b11, 1, 2'b01, 2'b00, 32'd0,  32'd13, 0, 32'd0);
      tbl[2]  = mk(0, 0, 0, 32'd0,  32'd0,  2'b11, 0, 2'b11, 2'b01, 32'd6,  32'd45, 0, 32'd0);
      tbl[3]  = mk(0, 0, 0, 32'd0,  32'd0,  2'b11, 1, 2'b10, 2'b10, 32'd27, 32'd45, 0, 32'd0);
      tbl[4]  = mk(0, 0, 0, 32'd0,  32'd0,  2'b11, 1, 2'b00, 2'b00, 32'd27, 32'd45, 1, 32'd0);
      // Scenario 2: same stream, lane 1 stalls 3 cycles while holding 6
      tbl[5]  = mk(1, 1, 0, 32'd6,  32'd13, 2'b11, 1, 2'b00, 2'b00, 32'd0,  32'd0,  0, 32'd0);
      tbl[6]  = mk(0, 1, 1, 32'd27, 32'd45, 2'b11, 1, 2'b01, 2'b00, 32'd0,  32'd13, 0, 32'd0);
      tbl[7]  = mk(0, 0, 0, 32'd0,  32'd0,  2'b01, 0, 2'b11, 2'b01, 32'd6,  32'd45, 0, 32'd0);
      tbl[8]  = mk(0, 0, 0, 32'd0,  32'd0,  2'b01, 0, 2'b11, 2'b01, 32'd6,  32'd45, 0, 32'd0);
      tbl[9]  = mk(0, 0, 0, 32'd0,  32'd0,  2'b01, 0, 2'b11, 2'b01, 32'd6,  32'd45, 0, 32'd0);
      tbl[10] = mk(0, 0, 0, 32'd0,  32'd0,  2'b11, 0, 2'b11, 2'b01, 32'd6,  32'd45, 1, 32'd3);
      tbl[11] = mk(0, 0, 0, 32'd0,  32'd0,  2'b11, 1, 2'b10, 2'b10, 32'd27, 32'd45, 1, 32'd3);
      tbl[12] = mk(0, 0, 0, 32'd0,  32'd0,  2'b11, 1, 2'b00, 2'b00, 32'd27, 32'd45, 0, 32'd0);
      // Scenario 3: back-to-back matrices, valid held high
      tbl[13] = mk(1, 1, 0, 32'd10,  32'hFFFF_FFDB, 2'b11, 1, 2'b00, 2'b00, 32'd0,   32'd0,        0, 32'd0);
      tbl[14] = mk(0, 1, 1, 32'd960, 32'd44,        2'b11, 1, 2'b01, 2'b00, 32'd0,   32'hFFFF_FFDB, 0, 32'd0);
      tbl[15] = mk(0, 1, 0, 32'd1,   32'd2,         2'b11, 0, 2'b11, 2'b01, 32'd10,  32'd44,       0, 32'd0);
      tbl[16] = mk(0, 1, 0, 32'd1,   32'd2,         2'b11, 1, 2'b10, 2'b10, 32'd960, 32'd44,       0, 32'd0);
      tbl[17] = mk(0, 0, 0, 32'd0,   32'd0,         2'b11, 1, 2'b01, 2'b00, 32'd960, 32'd2,        0, 32'd0);
      tbl[18] = mk(0, 0, 0, 32'd0,   32'd0,         2'b11, 1, 2'b10, 2'b00, 32'd1,   32'd2,        0, 32'd0);
      tbl[19] = mk(0, 0, 0, 32'd0,   32'd0,         2'b11, 1, 2'b00, 2'b00, 32'd1,   32'd2,        0, 32'd0);

      for (int i = 0; i < 20; i++) begin
         if (tbl[i].rst) begin
            drive(1'b0, 1'b0, 32'd0, 32'd0, 2'b11);
            do_reset();
         end
         drive(tbl[i].v, tbl[i].l, tbl[i].in1, tbl[i].in0, tbl[i].rdy);
         chk($sformatf("row%0d vec_ready", i), 32'(vec_ready),  32'(tbl[i].e_vr));
         chk($sformatf("row%0d valid", i),     32'(valid),      32'(tbl[i].e_valid));
         chk($sformatf("row%0d flush", i),     32'(flush),      32'(tbl[i].e_flush));
         chk($sformatf("row%0d data1", i),     data[63:32],     tbl[i].e_d1);
         chk($sformatf("row%0d data0", i),     data[31:0],      tbl[i].e_d0);
`ifdef SKEW_FEEDER_STALL_CNT_EN
         if (tbl[i].sc_chk) chk($sformatf("row%0d stall_cnt", i), stall_cnt, tbl[i].e_sc);
`endif
         step();
      end

      // Reset asserted while lane 1 holds 27 (last element of the matrix)
      drive(1'b0, 1'b0, 32'd0, 32'd0, 2'b11);
      do_reset();
      drive(1'b1, 1'b0, 32'd6, 32'd13, 2'b11);
      step();
      drive(1'b1, 1'b1, 32'd27, 32'd45, 2'b11);
      step();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 2'b11);
      step();
      chk("pre_reset valid", 32'(valid), 32'd2);
      chk("pre_reset flush", 32'(flush), 32'd2);
      reset_i = 1'b0;
      #1;
      chk("async_reset valid", 32'(valid), 32'd0);
      chk("async_reset flush", 32'(flush), 32'd0);
      chk("async_reset data", data[63:32] | data[31:0], 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset_i = 1'b1;
      step();
      chk("post_reset valid", 32'(valid), 32'd0);
      chk("post_reset flush", 32'(flush), 32'd0);
      chk("post_reset vec_ready", 32'(vec_ready), 32'd1);
      drive(1'b1, 1'b0, 32'd7, 32'd8, 2'b11);
      step();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 2'b11);
      chk("post_reset accept valid", 32'(valid), 32'd1);
      chk("post_reset accept data0", data[31:0], 32'd8);
      chk("post_reset accept flush", 32'(flush), 32'd0);
      step();
      chk("post_reset lane1 valid", 32'(valid), 32'd2);
      chk("post_reset lane1 data1", data[63:32], 32'd7);
      chk("post_reset lane1 flush", 32'(flush), 32'd0);
      step();
      chk("post_reset idle valid", 32'(valid), 32'd0);

      // One-lane instance: last slice does not block the next one
      vec1_valid = 1'b1; vec1_last = 1'b1; vec1 = 32'd5; ready1 = 1'b1;
      chk("l1 ready0", 32'(vec1_ready), 32'd1);
      step();
      vec1_valid = 1'b1; vec1_last = 1'b0; vec1 = 32'd9;
      chk("l1 ready after last", 32'(vec1_ready), 32'd1);
      chk("l1 valid 5", 32'(valid1), 32'd1);
      chk("l1 flush 5", 32'(flush1), 32'd1);
      chk("l1 data 5", data1, 32'd5);
      step();
      vec1_valid = 1'b0; vec1_last = 1'b0; vec1 = 32'd0;
      chk("l1 valid 9", 32'(valid1), 32'd1);
      chk("l1 flush 9", 32'(flush1), 32'd0);
      chk("l1 data 9", data1, 32'd9);
      step();
      chk("l1 idle valid", 32'(valid1), 32'd0);
      chk("l1 idle data held", data1, 32'd9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
